// File: rtl/mojo_uart.sv
// mojo_uart: full-duplex UART between the board serial pins and the
// register-window command logic. RX and TX are independent state machines
// on the same clock.
//
// Optional feature macro: UART_PARITY_EN
//   undefined : 8N1 frames, parity_err tied to 0
//   defined   : 8E1 frames (even parity bit after data bit 7); a byte with
//               a parity mismatch is dropped and parity_err pulses
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-low reset
//   rx           serial line in (idle high, asynchronous to clk)
//   tx           serial line out (idle high, registered)
//   rx_data      last good received byte
//   new_rx_data  one-cycle pulse: rx_data holds a new good byte
//   frame_err    one-cycle pulse: stop bit sampled low
//   parity_err   one-cycle pulse: parity mismatch
//   tx_data      byte to send, sampled when the request is accepted
//   new_tx_data  send request
//   tx_busy      transmitter occupied
//   rx_state     debug view of the RX state machine
//   tx_state     debug view of the TX state machine
//
// TX handshake: new_tx_data is a request qualified by tx_busy. A request
// is accepted on a rising edge where new_tx_data==1 and tx_busy==0;
// tx_data is captured on that edge. Requests seen while tx_busy==1 are
// dropped, never queued. RX has no back-pressure: new_rx_data is a plain
// one-cycle strobe.

module mojo_uart #(
  parameter int CLK_PER_BIT = 100,
  localparam int CTR_SIZE = $clog2(CLK_PER_BIT)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       tx,
  output logic [7:0] rx_data,
  output logic       new_rx_data,
  output logic       frame_err,
  output logic       parity_err,
  input  logic [7:0] tx_data,
  input  logic       new_tx_data,
  output logic       tx_busy,
  output logic [2:0] rx_state,
  output logic [2:0] tx_state
);

  localparam logic [CTR_SIZE-1:0] CTR_LAST = CTR_SIZE'(CLK_PER_BIT - 1);
  localparam logic [CTR_SIZE-1:0] CTR_HALF = CTR_SIZE'(CLK_PER_BIT / 2 - 1);
  localparam logic [CTR_SIZE-1:0] CTR_ONE  = CTR_SIZE'(1);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_st_t;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_st_t;
`else
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_st_t;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_st_t;
`endif

  // ---------------- RX ----------------
  rx_st_t              rx_st;
  logic                rx_meta, rs;
  logic [CTR_SIZE-1:0] rx_ctr;
  logic [2:0]          rx_idx;
  logic [7:0]          rx_shift;
`ifdef UART_PARITY_EN
  logic                rx_par_bad;
  logic                parity_err_r;
  assign parity_err = parity_err_r;
`else
  assign parity_err = 1'b0;
`endif

  assign rx_state = rx_st;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta     <= 1'b1;
      rs          <= 1'b1;
      rx_st       <= RX_IDLE;
      rx_ctr      <= '0;
      rx_idx      <= '0;
      rx_shift    <= '0;
      rx_data     <= '0;
      new_rx_data <= 1'b0;
      frame_err   <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_bad   <= 1'b0;
      parity_err_r <= 1'b0;
`endif
    end else begin
      rx_meta     <= rx;
      rs          <= rx_meta;
      new_rx_data <= 1'b0;
      frame_err   <= 1'b0;
`ifdef UART_PARITY_EN
      parity_err_r <= 1'b0;
`endif
      case (rx_st)
        RX_IDLE: begin
          rx_ctr <= '0;
          if (!rs) rx_st <= RX_START;
        end
        RX_START: begin
          // Re-check the start bit at its mid-point to reject glitches.
          if (rx_ctr == CTR_HALF) begin
            rx_ctr <= '0;
            rx_idx <= '0;
            rx_st  <= rs ? RX_IDLE : RX_DATA;
          end else begin
            rx_ctr <= rx_ctr + CTR_ONE;
          end
        end
        RX_DATA: begin
          if (rx_ctr == CTR_LAST) begin
            rx_ctr   <= '0;
            rx_shift <= {rs, rx_shift[7:1]};
            rx_idx   <= rx_idx + 3'd1;
`ifdef UART_PARITY_EN
            if (rx_idx == 3'd7) rx_st <= RX_PARITY;
`else
            if (rx_idx == 3'd7) rx_st <= RX_STOP;
`endif
          end else begin
            rx_ctr <= rx_ctr + CTR_ONE;
          end
        end
`ifdef UART_PARITY_EN
        RX_PARITY: begin
          if (rx_ctr == CTR_LAST) begin
            rx_ctr     <= '0;
            rx_par_bad <= rs ^ (^rx_shift);
            rx_st      <= RX_STOP;
          end else begin
            rx_ctr <= rx_ctr + CTR_ONE;
          end
        end
`endif
        RX_STOP: begin
          if (rx_ctr == CTR_LAST) begin
            rx_ctr <= '0;
            if (!rs) begin
              // Framing error wins over parity; wait for the line to
              // recover so a held break reports only once.
              frame_err <= 1'b1;
              rx_st     <= RX_WAIT_HIGH;
`ifdef UART_PARITY_EN
            end else if (rx_par_bad) begin
              parity_err_r <= 1'b1;
              rx_st        <= RX_IDLE;
`endif
            end else begin
              rx_data     <= rx_shift;
              new_rx_data <= 1'b1;
              rx_st       <= RX_IDLE;
            end
          end else begin
            rx_ctr <= rx_ctr + CTR_ONE;
          end
        end
        RX_WAIT_HIGH: begin
          if (rs) rx_st <= RX_IDLE;
        end
        default: rx_st <= RX_IDLE;
      endcase
    end
  end

  // ---------------- TX ----------------
  tx_st_t              tx_st;
  logic [CTR_SIZE-1:0] tx_ctr;
  logic [2:0]          tx_idx;
  logic [7:0]          tx_shift;
`ifdef UART_PARITY_EN
  logic                tx_par;
`endif

  assign tx_state = tx_st;

  // tx is driven straight from a flop; each state loads the level of the
  // next bit on its final cycle so every bit lasts exactly CLK_PER_BIT.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_st    <= TX_IDLE;
      tx_ctr   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      case (tx_st)
        TX_IDLE: begin
          tx     <= 1'b1;
          tx_ctr <= '0;
          if (new_tx_data) begin
            tx_shift <= tx_data;
`ifdef UART_PARITY_EN
            tx_par   <= ^tx_data;
`endif
            tx_busy  <= 1'b1;
            tx       <= 1'b0;
            tx_st    <= TX_START;
          end
        end
        TX_START: begin
          if (tx_ctr == CTR_LAST) begin
            tx_ctr <= '0;
            tx_idx <= '0;
            tx     <= tx_shift[0];
            tx_st  <= TX_DATA;
          end else begin
            tx_ctr <= tx_ctr + CTR_ONE;
          end
        end
        TX_DATA: begin
          if (tx_ctr == CTR_LAST) begin
            tx_ctr   <= '0;
            tx_idx   <= tx_idx + 3'd1;
            tx_shift <= {1'b0, tx_shift[7:1]};
            if (tx_idx == 3'd7) begin
`ifdef UART_PARITY_EN
              tx    <= tx_par;
              tx_st <= TX_PARITY;
`else
              tx    <= 1'b1;
              tx_st <= TX_STOP;
`endif
            end else begin
              tx <= tx_shift[1];
            end
          end else begin
            tx_ctr <= tx_ctr + CTR_ONE;
          end
        end
`ifdef UART_PARITY_EN
        TX_PARITY: begin
          if (tx_ctr == CTR_LAST) begin
            tx_ctr <= '0;
            tx     <= 1'b1;
            tx_st  <= TX_STOP;
          end else begin
            tx_ctr <= tx_ctr + CTR_ONE;
          end
        end
`endif
        TX_STOP: begin
          if (tx_ctr == CTR_LAST) begin
            tx_ctr  <= '0;
            tx_busy <= 1'b0;
            tx_st   <= TX_IDLE;
          end else begin
            tx_ctr <= tx_ctr + CTR_ONE;
          end
        end
        default: tx_st <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mojo_uart.sv
// Testbench for mojo_uart with CLK_PER_BIT=8. Inputs change 1 time unit
// after a rising edge; outputs are read at that same point or on the
// falling edge (RX strobe monitor).
module tb_mojo_uart;
  localparam int CPB = 8;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
  localparam int EXP_LAT = 87;
`else
  localparam int NB = 10;
  localparam int EXP_LAT = 79;
`endif

  // ---- clock / reset ----
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       rx = 1'b1;
  logic       tx;
  logic [7:0] rx_data;
  logic       new_rx_data, frame_err, parity_err;
  logic [7:0] tx_data = 8'h00;
  logic       new_tx_data = 1'b0;
  logic       tx_busy;
  logic [2:0] rx_state, tx_state;

  mojo_uart #(.CLK_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rx(rx), .tx(tx),
    .rx_data(rx_data), .new_rx_data(new_rx_data),
    .frame_err(frame_err), .parity_err(parity_err),
    .tx_data(tx_data), .new_tx_data(new_tx_data), .tx_busy(tx_busy),
    .rx_state(rx_state), .tx_state(tx_state)
  );

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---- scoreboard ----
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int got_cyc_q[$];
  int ferr_cnt = 0;
  int perr_cnt = 0;
  logic rx_bad_par = 1'b0;

  always @(negedge clk) begin
    if (new_rx_data) begin
      got_q.push_back(rx_data);
      got_cyc_q.push_back(cyc);
    end
    if (frame_err) ferr_cnt++;
    if (parity_err) perr_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish (time %0t, limit 400000)", $time);
    $fatal(1);
  end

  // ---- driver tasks ----
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one frame; leaves rx at the stop-bit level.
  task automatic send_rx(input logic [7:0] d, input logic stop_bit);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(CPB);
    end
`ifdef UART_PARITY_EN
    rx = (^d) ^ rx_bad_par;
    tick(CPB);
`endif
    rx = stop_bit;
    tick(CPB);
  endtask

  // Requests one byte and checks the line and tx_busy every cycle.
  task automatic tx_frame(input logic [7:0] d, input bit dup);
    logic frame [NB];
    frame[0] = 1'b0;
    for (int i = 0; i < 8; i++) frame[i+1] = d[i];
`ifdef UART_PARITY_EN
    frame[9] = ^d;
`endif
    frame[NB-1] = 1'b1;
    tx_data = d;
    new_tx_data = 1'b1;
    tick(1);
    new_tx_data = 1'b0;
    for (int k = 0; k < NB * CPB; k++) begin
      if (dup && k == 20) begin
        tx_data = 8'hFF;
        new_tx_data = 1'b1;
      end
      if (k == 21) new_tx_data = 1'b0;
      n_total++;
      if (tx !== frame[k/CPB])
        $display("FAIL tx_bit byte=%h cycle %0d: got %b want %b", d, k, tx, frame[k/CPB]);
      else n_pass++;
      n_total++;
      if (tx_busy !== 1'b1)
        $display("FAIL tx_busy_high byte=%h cycle %0d: got %b want 1", d, k, tx_busy);
      else n_pass++;
      tick(1);
    end
    n_total++;
    if (tx_busy !== 1'b0 || tx !== 1'b1)
      $display("FAIL tx_end byte=%h: got busy=%b tx=%b want busy=0 tx=1", d, tx_busy, tx);
    else n_pass++;
  endtask

  // ---- tests ----
  task automatic test_reset;
    rst = 1'b0;
    tick(3);
    n_total++; if (tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx); else n_pass++;
    n_total++; if (tx_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", tx_busy); else n_pass++;
    n_total++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h want 00", rx_data); else n_pass++;
    n_total++; if (new_rx_data !== 1'b0) $display("FAIL reset_new_rx: got %b want 0", new_rx_data); else n_pass++;
    n_total++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b want 0", frame_err); else n_pass++;
    n_total++; if (parity_err !== 1'b0) $display("FAIL reset_parity_err: got %b want 0", parity_err); else n_pass++;
    n_total++; if (rx_state !== 3'd0 || tx_state !== 3'd0)
      $display("FAIL reset_state: got rx=%0d tx=%0d want 0 0", rx_state, tx_state); else n_pass++;
    rst = 1'b1;
    tick(5);
  endtask

  task automatic test_rx_good;
    int t0, f0, lat;
    logic [7:0] e;
    got_q.delete(); got_cyc_q.delete();
    f0 = ferr_cnt;
    exp_q.push_back(8'hA5);
    t0 = cyc;
    send_rx(8'hA5, 1'b1);
    rx = 1'b1;
    tick(10);
    e = exp_q.pop_front();
    n_total++;
    if (got_q.size() != 1) $display("FAIL rx_good_count: got %0d pulses want 1", got_q.size());
    else n_pass++;
    if (got_q.size() > 0) begin
      lat = got_cyc_q[0] - t0;
      n_total++;
      if (got_q[0] !== e) $display("FAIL rx_good_data: got %h want %h", got_q[0], e); else n_pass++;
      n_total++;
      if (lat < EXP_LAT - 2 || lat > EXP_LAT + 2)
        $display("FAIL rx_good_latency: got %0d want %0d", lat, EXP_LAT);
      else n_pass++;
    end
    n_total++;
    if (ferr_cnt != f0) $display("FAIL rx_good_frame_err: got %0d want %0d", ferr_cnt, f0); else n_pass++;
  endtask

  task automatic test_rx_glitch;
    int f0;
    got_q.delete();
    f0 = ferr_cnt;
    rx = 1'b0;
    tick(2);
    rx = 1'b1;
    tick(12);
    n_total++;
    if (got_q.size() != 0 || ferr_cnt != f0)
      $display("FAIL rx_glitch_pulse: got rx=%0d ferr=%0d want 0 0", got_q.size(), ferr_cnt - f0);
    else n_pass++;
    n_total++;
    if (rx_state !== 3'd0) $display("FAIL rx_glitch_idle: got state %0d want 0", rx_state); else n_pass++;
    exp_q.push_back(8'h3C);
    send_rx(8'h3C, 1'b1);
    rx = 1'b1;
    tick(10);
    n_total++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0])
      $display("FAIL rx_after_glitch: got %0d bytes first=%h want 1 byte %h", got_q.size(), got_q.size() ? got_q[0] : 8'hxx, exp_q[0]);
    else n_pass++;
    void'(exp_q.pop_front());
  endtask

  task automatic test_rx_break;
    int f0;
    got_q.delete();
    f0 = ferr_cnt;
    send_rx(8'h00, 1'b0);
    tick(40);
    rx = 1'b1;
    tick(10);
    n_total++;
    if (ferr_cnt - f0 != 1) $display("FAIL break_frame_err: got %0d pulses want 1", ferr_cnt - f0); else n_pass++;
    n_total++;
    if (got_q.size() != 0) $display("FAIL break_new_rx: got %0d pulses want 0", got_q.size()); else n_pass++;
    n_total++;
    if (rx_data !== 8'h3C) $display("FAIL break_rx_data_kept: got %h want 3c", rx_data); else n_pass++;
    exp_q.push_back(8'h5A);
    send_rx(8'h5A, 1'b1);
    rx = 1'b1;
    tick(10);
    n_total++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0])
      $display("FAIL rx_after_break: got %0d bytes first=%h want 1 byte %h", got_q.size(), got_q.size() ? got_q[0] : 8'hxx, exp_q[0]);
    else n_pass++;
    void'(exp_q.pop_front());
  endtask

  task automatic test_tx;
    tx_frame(8'h81, 1'b1);
    // The request made mid-frame must have been dropped.
    for (int k = 0; k < 30; k++) begin
      n_total++;
      if (tx !== 1'b1 || tx_busy !== 1'b0)
        $display("FAIL tx_ignored_req cycle %0d: got tx=%b busy=%b want 1 0", k, tx, tx_busy);
      else n_pass++;
      tick(1);
    end
  endtask

  task automatic test_reset_mid;
    int f0, p0;
    got_q.delete();
    f0 = ferr_cnt;
    p0 = perr_cnt;
    fork
      begin
        tx_data = 8'h55;
        new_tx_data = 1'b1;
        tick(1);
        new_tx_data = 1'b0;
      end
      begin
        tick(17);
        send_rx(8'hF8, 1'b1);
        rx = 1'b1;
      end
      begin
        tick(52);
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        n_total++;
        if (tx !== 1'b1 || tx_busy !== 1'b0)
          $display("FAIL mid_reset_tx: got tx=%b busy=%b want 1 0", tx, tx_busy);
        else n_pass++;
        n_total++;
        if (rx_state !== 3'd0 || tx_state !== 3'd0)
          $display("FAIL mid_reset_state: got rx=%0d tx=%0d want 0 0", rx_state, tx_state);
        else n_pass++;
      end
    join
    tick(20);
    n_total++;
    if (got_q.size() != 0 || ferr_cnt != f0 || perr_cnt != p0)
      $display("FAIL mid_reset_pulses: got rx=%0d ferr=%0d perr=%0d want 0 0 0", got_q.size(), ferr_cnt - f0, perr_cnt - p0);
    else n_pass++;
    n_total++;
    if (tx !== 1'b1 || tx_busy !== 1'b0)
      $display("FAIL mid_reset_tx_idle: got tx=%b busy=%b want 1 0", tx, tx_busy);
    else n_pass++;
    exp_q.push_back(8'h42);
    send_rx(8'h42, 1'b1);
    rx = 1'b1;
    tick(10);
    n_total++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0])
      $display("FAIL rx_after_reset: got %0d bytes first=%h want 1 byte %h", got_q.size(), got_q.size() ? got_q[0] : 8'hxx, exp_q[0]);
    else n_pass++;
    void'(exp_q.pop_front());
    tx_frame(8'h42, 1'b0);
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity;
    int f0, p0;
    got_q.delete();
    f0 = ferr_cnt;
    p0 = perr_cnt;
    rx_bad_par = 1'b1;  // 0x07 needs parity 1; send 0
    send_rx(8'h07, 1'b1);
    rx_bad_par = 1'b0;
    rx = 1'b1;
    tick(10);
    n_total++;
    if (perr_cnt - p0 != 1) $display("FAIL parity_err_pulse: got %0d want 1", perr_cnt - p0); else n_pass++;
    n_total++;
    if (got_q.size() != 0 || ferr_cnt != f0)
      $display("FAIL parity_drop: got rx=%0d ferr=%0d want 0 0", got_q.size(), ferr_cnt - f0);
    else n_pass++;
    tx_frame(8'h07, 1'b0);
  endtask
`else
  task automatic test_no_parity;
    n_total++;
    if (perr_cnt != 0) $display("FAIL parity_err_tied: got %0d pulses want 0", perr_cnt); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_rx_good();
    test_rx_glitch();
    test_rx_break();
    test_tx();
    test_reset_mid();
`ifdef UART_PARITY_EN
    test_parity();
`else
    test_no_parity();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mojo_uart.md
Name: mojo_uart

Overview:
- Full-duplex 8N1 UART between the board serial pins and the register-window command logic.
- It produces the byte stream the command logic parses (ser_rx_data / ser_new_rx_data).
- It serialises the bytes the command logic returns (ser_tx_data / ser_new_tx_data / ser_tx_busy).
- RX and TX are independent state machines driven by the same clock.

Parameters:
CLK_PER_BIT, 100, clock cycles per bit (50 MHz / 500 kbaud); legal minimum 4
CTR_SIZE, $clog2(CLK_PER_BIT), width of bit-timing counters (derived, not overridden)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, synchronous, active-low (rst==0 at a clk edge resets every register)
rx  input  1  serial line in, idle high, asynchronous to clk
tx  output  1  serial line out, idle high
rx_data  output  8  last received byte, valid when new_rx_data=1
new_rx_data  output  1  one-cycle pulse: good byte received
frame_err  output  1  one-cycle pulse: stop bit sampled low
parity_err  output  1  one-cycle pulse: parity mismatch (tied 0 without UART_PARITY_EN)
tx_data  input  8  byte to send, sampled when accepted
new_tx_data  input  1  send request, accepted only while tx_busy=0
tx_busy  output  1  transmitter occupied

Behaviour:
- Reset values: tx=1, tx_busy=0, rx_data=0, new_rx_data=0, frame_err=0, parity_err=0. Both FSMs go to IDLE, counters to 0. Synchroniser flops reset to 1.
- Reset mid-frame abandons the frame; no pulse is emitted for it.
- RX input path: rx passes through a 2-flop synchroniser. All RX decisions use the synchronised value rs.
- RX FSM states: IDLE, START, DATA, [PARITY], STOP, WAIT_HIGH.
  - IDLE: rs==0 -> START, ctr=0.
  - START: at ctr==CLK_PER_BIT/2-1, sample rs. If rs==0 -> DATA with ctr=0, bit index=0. If rs==1 (glitch) -> IDLE, no pulse.
  - DATA: every CLK_PER_BIT cycles (ctr==CLK_PER_BIT-1), shift rs into data LSB-first. After bit 7 -> PARITY if enabled, else STOP.
  - PARITY: sample after one bit time, compare with computed parity -> STOP.
  - STOP: sample after one bit time.
    - rs==1 and parity OK: rx_data<=shift reg and new_rx_data=1 on the next cycle -> IDLE.
    - rs==1 and parity bad: parity_err=1, rx_data unchanged -> IDLE.
    - rs==0: frame_err=1, rx_data unchanged -> WAIT_HIGH. frame_err takes priority over parity_err; only one pulse per frame.
  - WAIT_HIGH: stay until rs==1 -> IDLE. A held-low break line produces exactly one frame_err.
- RX latency: the pulse occurs 1 cycle after the stop-bit mid-point sample. That is about (9.5 bit times + 3) cycles after the line's falling edge, 8N1.
- TX FSM states: IDLE, START, DATA, [PARITY], STOP.
  - IDLE: new_tx_data==1 -> latch tx_data, tx_busy<=1, -> START, ctr=0. tx stays 1 in the acceptance cycle.
  - START: tx=0 for CLK_PER_BIT cycles.
  - DATA: tx = bit[i], LSB first, CLK_PER_BIT cycles each, i=0..7.
  - PARITY: tx = parity bit for CLK_PER_BIT cycles.
  - STOP: tx=1 for CLK_PER_BIT cycles. On the last cycle tx_busy<=0 -> IDLE.
- TX timing: tx_busy is high for exactly 10*CLK_PER_BIT cycles (11 with parity). A new request is accepted the cycle tx_busy is observed 0.
- new_tx_data while tx_busy==1 is ignored: not queued, no corruption.
- RX and TX operate simultaneously with no interaction. A loopback (tx tied to rx) reproduces each sent byte.
- tx is a registered output and is glitch-free.

Optional Feature:
- Macro: UART_PARITY_EN.
- Defined: an even-parity bit follows data bit 7 on both RX and TX (frame 8E1). parity_err pulses on mismatch and the byte is dropped.
- Undefined: 8N1, PARITY states absent, parity_err constant 0.

Test Plan:
- Test 1, RX good byte (CLK_PER_BIT=8):
  - Stimulus: drive 0xA5 frame on rx.
  - Required: single new_rx_data pulse with rx_data=0xA5 about 79 cycles after start edge; frame_err=0.
- Test 2, RX glitch:
  - Stimulus: rx low for 2 cycles, then high.
  - Required: no new_rx_data or frame_err pulse; RX returns to IDLE; the next frame 0x3C is received correctly.
- Test 3, RX break:
  - Stimulus: byte 0x00 with stop bit low, rx held low for 40 more cycles, then high, then frame 0x5A.
  - Required: exactly one frame_err pulse, no new_rx_data for the bad frame, then new_rx_data with 0x5A.
- Test 4, TX:
  - Stimulus: request 0x81; issue a second request 0xFF 20 cycles later.
  - Required: tx = 0,1,0,0,0,0,0,0,1,1, each 8 cycles; tx_busy high 80 cycles; the 0xFF request is ignored (line idle afterwards).
- Test 5, reset mid-frame:
  - Stimulus: rst=0 for 1 cycle during RX data bit 3 and TX data bit 5.
  - Required: tx=1, tx_busy=0, no pulses; the following 0x42 RX frame and 0x42 TX request complete correctly.
- Test 6, parity (UART_PARITY_EN defined):
  - Stimulus: RX frame 0x07 with parity bit 0.
  - Required: parity_err pulse, no new_rx_data.
  - Stimulus: TX 0x07.
  - Required: parity bit 1 on tx; tx_busy high 88 cycles.
